// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE-754 multiplier: width helpers, flag indices,
// operand classification and canonical encodings.
package fp_pkg;

    localparam int DEF_EXP_W = 5;
    localparam int DEF_MAN_W = 10;

    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_SNAN,
        CLS_QNAN
    } fp_class_e;

    typedef enum logic [1:0] {
        SPC_NONE,
        SPC_ZERO,
        SPC_INF,
        SPC_NAN
    } fp_spc_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    function automatic int fp_sig_w(input int man_w);
        return man_w + 1;
    endfunction

    localparam int BIAS    = fp_bias(DEF_EXP_W);
    localparam int EXP_MAX = fp_exp_max(DEF_EXP_W);
    localparam int SIG_W   = fp_sig_w(DEF_MAN_W);

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] e_ones;
        e_ones = (64'd1 << exp_w) - 64'd1;
        return (e_ones << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w, input logic sign);
        logic [63:0] e_ones;
        e_ones = (64'd1 << exp_w) - 64'd1;
        return ({63'd0, sign} << (exp_w + man_w)) | (e_ones << man_w);
    endfunction

    function automatic logic [63:0] fp_zero(input int exp_w, input int man_w, input logic sign);
        return {63'd0, sign} << (exp_w + man_w);
    endfunction

    function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                              input logic frac_nz, input logic frac_msb);
        if (exp_ones) begin
            if (!frac_nz)     return CLS_INF;
            else if (frac_msb) return CLS_QNAN;
            else              return CLS_SNAN;
        end
        if (exp_zero) return frac_nz ? CLS_SUB : CLS_ZERO;
        return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_sig_mul.sv
// Unsigned significand multiplier: carry-save accumulation of partial products,
// single carry-propagate add at the end.
module fp_sig_mul #(
    parameter int SW = 11
) (
    input  logic [SW-1:0]   a_i,
    input  logic [SW-1:0]   b_i,
    output logic [2*SW-1:0] p_o
);

    localparam int PW = 2 * SW;

    logic [PW-1:0] sum, carry, carry_n, pp, mcand;
    logic [SW-1:0] mplier;

    always_comb begin
        sum     = '0;
        carry   = '0;
        carry_n = '0;
        pp      = '0;
        mcand   = PW'(a_i);
        mplier  = b_i;
        for (int unsigned i = 0; i < SW; i++) begin
            pp      = mplier[0] ? mcand : '0;
            carry_n = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
            sum     = sum ^ carry ^ pp;
            carry   = carry_n;
            mcand   = mcand << 1;
            mplier  = mplier >> 1;
        end
        p_o = sum + carry;
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// 3-stage IEEE-754 multiplier (DAZ/FTZ, RNE) with valid/ready flow control.
// S1 classify + significand product, S2 normalise + GRS, S3 round + pack.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [EXP_W+MAN_W:0]     i_op_a,
    input  logic [EXP_W+MAN_W:0]     i_op_b,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [EXP_W+MAN_W:0]     o_result,
    output logic [3:0]               o_flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = fp_sig_w(MAN_W);
    localparam int PW = 2 * SW;
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] BIAS_E = EW'(fp_bias(EXP_W));
    localparam logic [EW-1:0] EMAX_E = EW'(fp_exp_max(EXP_W));
    localparam logic [W-1:0]  QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    logic advance;

    // ---------------- S1 ----------------
    logic               sign_a, sign_b;
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [MAN_W-1:0]   frac_a, frac_b;
    fp_class_e          cls_a, cls_b;
    logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, snan_ab;
    logic [PW-1:0]      prod;
    fp_spc_e            s1_spc_d;
    logic               s1_inv_d;

    logic               s1_valid_q, s1_inv_q, s1_sign_q;
    fp_spc_e            s1_spc_q;
    logic [EW-1:0]      s1_esum_q;
    logic [PW-1:0]      s1_prod_q;

    assign sign_a = i_op_a[W-1];
    assign sign_b = i_op_b[W-1];
    assign exp_a  = i_op_a[W-2 -: EXP_W];
    assign exp_b  = i_op_b[W-2 -: EXP_W];
    assign frac_a = i_op_a[MAN_W-1:0];
    assign frac_b = i_op_b[MAN_W-1:0];

    assign cls_a = fp_classify(&exp_a, ~|exp_a, |frac_a, frac_a[MAN_W-1]);
    assign cls_b = fp_classify(&exp_b, ~|exp_b, |frac_b, frac_b[MAN_W-1]);

    assign nan_a   = (cls_a == CLS_SNAN) || (cls_a == CLS_QNAN);
    assign nan_b   = (cls_b == CLS_SNAN) || (cls_b == CLS_QNAN);
    assign inf_a   = (cls_a == CLS_INF);
    assign inf_b   = (cls_b == CLS_INF);
    assign zero_a  = (cls_a == CLS_ZERO) || (cls_a == CLS_SUB);
    assign zero_b  = (cls_b == CLS_ZERO) || (cls_b == CLS_SUB);
    assign snan_ab = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);

    always_comb begin
        s1_spc_d = SPC_NONE;
        s1_inv_d = 1'b0;
        if (nan_a || nan_b) begin
            s1_spc_d = SPC_NAN;
            s1_inv_d = snan_ab;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            s1_spc_d = SPC_NAN;
            s1_inv_d = 1'b1;
        end else if (inf_a || inf_b) begin
            s1_spc_d = SPC_INF;
        end else if (zero_a || zero_b) begin
            s1_spc_d = SPC_ZERO;
        end
    end

    fp_sig_mul #(.SW(SW)) u_sig_mul (
        .a_i ({1'b1, frac_a}),
        .b_i ({1'b1, frac_b}),
        .p_o (prod)
    );

    assign advance = ~o_valid | i_ready;
    assign o_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_spc_q   <= SPC_NONE;
            s1_inv_q   <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_esum_q  <= '0;
            s1_prod_q  <= '0;
        end else if (advance) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_spc_q  <= s1_spc_d;
                s1_inv_q  <= s1_inv_d;
                s1_sign_q <= sign_a ^ sign_b;
                s1_esum_q <= EW'(exp_a) + EW'(exp_b);
                s1_prod_q <= prod;
            end
        end
    end

    // ---------------- S2 ----------------
    logic               norm;
    logic [MAN_W-1:0]   s2_frac_d;
    logic [2:0]         s2_grs_d;
    logic [EW-1:0]      s2_exp_d;

    logic               s2_valid_q, s2_inv_q, s2_sign_q;
    fp_spc_e            s2_spc_q;
    logic [EW-1:0]      s2_exp_q;
    logic [MAN_W-1:0]   s2_frac_q;
    logic [2:0]         s2_grs_q;

    // Product lies in [1,4): select the fraction/GRS window instead of shifting.
    assign norm      = s1_prod_q[PW-1];
    assign s2_frac_d = norm ? s1_prod_q[PW-2 -: MAN_W] : s1_prod_q[PW-3 -: MAN_W];
    assign s2_grs_d  = norm ? {s1_prod_q[SW-1], s1_prod_q[SW-2], |s1_prod_q[SW-3:0]}
                            : {s1_prod_q[SW-2], s1_prod_q[SW-3], |s1_prod_q[SW-4:0]};
    assign s2_exp_d  = s1_esum_q - BIAS_E + EW'(norm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_spc_q   <= SPC_NONE;
            s2_inv_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_frac_q  <= '0;
            s2_grs_q   <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_spc_q  <= s1_spc_q;
                s2_inv_q  <= s1_inv_q;
                s2_sign_q <= s1_sign_q;
                s2_exp_q  <= s2_exp_d;
                s2_frac_q <= s2_frac_d;
                s2_grs_q  <= s2_grs_d;
            end
        end
    end

    // ---------------- S3 ----------------
    logic               rnd_up, rnd_carry, inexact;
    logic [MAN_W-1:0]   frac_r;
    logic [EW-1:0]      exp_r;
    logic [W-1:0]       res_d;
    logic [3:0]         flags_d;

    logic               s3_valid_q;
    logic [W-1:0]       s3_res_q;
    logic [3:0]         s3_flags_q;

    assign rnd_up    = s2_grs_q[2] & (s2_grs_q[1] | s2_grs_q[0] | s2_frac_q[0]);
    // An all-ones fraction wraps to zero on round-up; the carry moves into the exponent.
    assign rnd_carry = rnd_up & (&s2_frac_q);
    assign frac_r    = s2_frac_q + MAN_W'(rnd_up);
    assign exp_r     = s2_exp_q + EW'(rnd_carry);
    assign inexact   = |s2_grs_q;

    always_comb begin
        res_d   = '0;
        flags_d = '0;
        unique case (s2_spc_q)
            SPC_NAN: begin
                res_d                = QNAN;
                flags_d[FLG_INVALID] = s2_inv_q;
            end
            SPC_INF:  res_d = W'(fp_inf(EXP_W, MAN_W, s2_sign_q));
            SPC_ZERO: res_d = W'(fp_zero(EXP_W, MAN_W, s2_sign_q));
            default: begin
                if ($signed(exp_r) >= $signed(EMAX_E)) begin
                    res_d                 = W'(fp_inf(EXP_W, MAN_W, s2_sign_q));
                    flags_d[FLG_OVERFLOW] = 1'b1;
                    flags_d[FLG_INEXACT]  = 1'b1;
                end else if ($signed(exp_r) <= 0) begin
                    res_d                  = W'(fp_zero(EXP_W, MAN_W, s2_sign_q));
                    flags_d[FLG_UNDERFLOW] = 1'b1;
                    flags_d[FLG_INEXACT]   = 1'b1;
                end else begin
                    res_d                = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
                    flags_d[FLG_INEXACT] = inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            s3_res_q   <= '0;
            s3_flags_q <= '0;
        end else if (advance) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_res_q   <= res_d;
                s3_flags_q <= flags_d;
            end
        end
    end

    assign o_valid  = s3_valid_q;
    assign o_result = s3_res_q;
    assign o_flags  = s3_flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe (binary16): directed vectors, backpressure,
// reset mid-stream and randomized traffic against a real-arithmetic reference.
module tb_fp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [15:0] i_op_a = '0;
    logic [15:0] i_op_b = '0;
    logic        o_ready, o_valid;
    logic [15:0] o_result;
    logic [3:0]  o_flags;

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op_a   (i_op_a),
        .i_op_b   (i_op_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_flags  (o_flags)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [19:0] exp_q[$];
    bit          held_v = 1'b0;
    logic [19:0] held   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    // Reference: exact product in real arithmetic, then round-to-nearest-even to half.
    function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        logic sign;
        int   ea, eb, fa, fb, e, sig, be;
        bit   a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
        real  v, m, q, fl, fr;
        logic [4:0] be5;
        logic [9:0] f10;
        sign = a[15] ^ b[15];
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        a_nan  = (ea == 31) && (fa != 0);  b_nan  = (eb == 31) && (fb != 0);
        a_snan = a_nan && !a[9];           b_snan = b_nan && !b[9];
        a_inf  = (ea == 31) && (fa == 0);  b_inf  = (eb == 31) && (fb == 0);
        a_zero = (ea == 0);                b_zero = (eb == 0);
        if (a_nan || b_nan) return {a_snan || b_snan, 3'b000, 16'h7E00};
        if ((a_inf && b_zero) || (b_inf && a_zero)) return {4'b1000, 16'h7E00};
        if (a_inf || b_inf) return {4'b0000, sign, 15'h7C00};
        if (a_zero || b_zero) return {4'b0000, sign, 15'h0000};
        v = real'(1024 + fa) * (2.0 ** (ea - 25)) * real'(1024 + fb) * (2.0 ** (eb - 25));
        m = v; e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        q  = m * 1024.0;
        fl = $floor(q);
        fr = q - fl;
        sig = int'(fl);
        if (fr > 0.5 || (fr == 0.5 && (sig % 2) == 1)) sig++;
        if (sig == 2048) begin sig = 1024; e++; end
        be = e + 15;
        if (be >= 31) return {4'b0101, sign, 15'h7C00};
        if (be <= 0)  return {4'b0011, sign, 15'h0000};
        be5 = be[4:0];
        f10 = sig[9:0];
        return {3'b000, fr != 0.0, sign, be5, f10};
    endfunction

    function automatic logic [15:0] rand_op();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 11))
            0:       return {s, 15'h0000};
            1:       return {s, 15'h7C00};
            2:       return {s, 5'h1F, 1'b1, 9'($urandom)};
            3:       return {s, 5'h1F, 1'b0, 9'($urandom) | 9'h001};
            4:       return {s, 5'h00, 10'($urandom)};
            default: return {s, 5'($urandom_range(1, 30)), 10'($urandom)};
        endcase
    endfunction

    // One cycle: drive at negedge, sample 1 ns later, score handshakes for the next posedge.
    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                        input bit rdy, output bit accepted);
        logic [19:0] e;
        @(negedge clk);
        i_valid = v; i_op_a = a; i_op_b = b; i_ready = rdy;
        #1;
        if (held_v) begin
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_hold", 32'({o_flags, o_result}), 32'(held));
        end
        chk("o_ready", 32'(o_ready), 32'(!o_valid || i_ready));
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) chk("spurious_valid", 32'(o_valid), 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("result", 32'(o_result), 32'(e[15:0]));
                chk("flags", 32'(o_flags), 32'(e[19:16]));
            end
        end
        held_v = o_valid && !i_ready;
        held   = {o_flags, o_result};
        accepted = i_valid && o_ready;
        if (accepted) exp_q.push_back(ref_mul(a, b));
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] er, input logic [3:0] ef);
        @(negedge clk);
        i_valid = 1'b1; i_op_a = a; i_op_b = b; i_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            #1;
            if (k < 3) chk({tag, "_early"}, 32'(o_valid), 32'd0);
            else begin
                chk({tag, "_valid"}, 32'(o_valid), 32'd1);
                chk({tag, "_res"}, 32'(o_result), 32'(er));
                chk({tag, "_flags"}, 32'(o_flags), 32'(ef));
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        bit acc;
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1'b0, 16'h0, 16'h0, 1'($urandom_range(0, 1)), acc);
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          idx, cyc;
        logic [15:0] ba[8], bb[8], ra, rb;
        bit          rv;

        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_flags", 32'(o_flags), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        directed("exact1",  16'h3E00, 16'h4000, 16'h4200, 4'h0);
        directed("exact2",  16'h3E00, 16'h3E00, 16'h4080, 4'h0);
        directed("rne_tie", 16'h3C01, 16'h3E00, 16'h3E02, 4'h1);
        directed("sticky",  16'h3C01, 16'h3C01, 16'h3C02, 4'h1);
        directed("inf_x0",  16'h7C00, 16'h0000, 16'h7E00, 4'h8);
        directed("ninf_x2", 16'hFC00, 16'h4000, 16'hFC00, 4'h0);
        directed("qnan",    16'h7E00, 16'h3C00, 16'h7E00, 4'h0);
        directed("snan",    16'h7C01, 16'h3C00, 16'h7E00, 4'h8);
        directed("ovf",     16'h7BFF, 16'h4000, 16'h7C00, 4'h5);
        directed("unf",     16'h0400, 16'h3800, 16'h0000, 4'h3);
        directed("daz",     16'h0001, 16'h7BFF, 16'h0000, 4'h0);
        directed("rnd_ovf", 16'h7BFF, 16'h3C01, 16'h7C00, 4'h5);

        // Backpressure: 8 back-to-back pairs, sink ready pattern 1,0,0,1,...
        for (int k = 0; k < 8; k++) begin ba[k] = rand_op(); bb[k] = rand_op(); end
        idx = 0; cyc = 0;
        while (idx < 8 && cyc < 100) begin
            step(1'b1, ba[idx], bb[idx], ((cyc % 4) == 0) || ((cyc % 4) == 3), acc);
            if (acc) idx++;
            cyc++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd8);
        drain("bp", 100);

        // Reset with three items in flight and one result already presented.
        for (int k = 0; k < 3; k++) step(1'b1, 16'h3E00 + 16'(k), 16'h4000, 1'b0, acc);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(o_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_result", 32'(o_result), 32'd0);
        chk("mid_rst_flags", 32'(o_flags), 32'd0);
        exp_q.delete();
        held_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b0, 16'h0, 16'h0, 1'b1, acc);
        directed("post_rst", 16'h3E00, 16'h4000, 16'h4200, 4'h0);

        // Randomized traffic with random source/sink gaps; unaccepted pairs are held.
        ra = rand_op(); rb = rand_op(); rv = 1'b1;
        for (int n = 0; n < 600; n++) begin
            step(rv, ra, rb, $urandom_range(0, 3) != 0, acc);
            if (acc || !rv) begin
                ra = rand_op(); rb = rand_op();
                rv = $urandom_range(0, 3) != 0;
            end
        end
        drain("rand", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
